// File: rtl/poker_types_pkg.sv
// poker_types: shared card/deck types, dealer states and the index-to-card table
package poker_types;
  localparam int DECK_SIZE = 52;
  typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
  typedef logic [3:0] rank_t;
  typedef struct packed {
    suit_t suit;
    rank_t rank;
  } card_t;
  typedef enum logic [1:0] {EMPTY, INIT, SHUFFLE, READY} state_t;
  // suit is found by range compare and rank by subtracting the suit base, so no divider is built
  function automatic card_t idx_to_card(input logic [5:0] idx);
    logic [5:0] base;
    base = idx < 6'd13 ? 6'd0 : idx < 6'd26 ? 6'd13 : idx < 6'd39 ? 6'd26 : 6'd39;
    return '{suit: suit_t'(base == 6'd0 ? 2'd0 : base == 6'd13 ? 2'd1 : base == 6'd26 ? 2'd2 : 2'd3),
             rank: rank_t'(idx - base + 6'd2)};
  endfunction
endpackage

// File: rtl/card_dealer_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (taps 16'hB400) with load and step enable, exposing its low 6 bits
module lfsr16 #(
  parameter logic [15:0] INIT = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [5:0]  r_o
);
  logic [15:0] q_q;
  // load wins over step; shift right and fold the tap mask in when the dropped bit is set
  always_ff @(posedge clk or negedge reset)
    if (!reset) q_q <= INIT;
    else if (load_i) q_q <= seed_i;
    else if (en_i) q_q <= q_q[0] ? (q_q >> 1) ^ 16'hB400 : q_q >> 1;
  assign r_o = q_q[5:0];
endmodule

// File: rtl/card_dealer.sv
// card_dealer: builds, Fisher-Yates shuffles and deals a 52-card deck on request
module card_dealer
  import poker_types::*;
#(
  parameter bit          SHUFFLE_EN   = 1'b1,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shuffle_req,
  input  logic [15:0] seed,
  input  logic        deal_req,
  output logic        deal_valid,
  output logic [5:0]  deal_card,
  output logic        deal_err,
  output logic        deck_ready,
  output logic [5:0]  cards_left
);
  state_t     state_q, state_d;
  logic [5:0] i_q, i_d, ptr_q, ptr_d, left_q, left_d;
  logic       valid_q, valid_d, err_q, err_d;
  card_t      card_q, card_d;
  logic [5:0] deck_q [DECK_SIZE];
  logic [5:0] r;
  logic       shuffle_ok, swap;
  assign shuffle_ok = shuffle_req && (state_q == EMPTY || state_q == READY);
  assign swap = state_q == SHUFFLE && r <= i_q;
  lfsr16 #(.INIT(DEFAULT_SEED)) u_lfsr (
    .clk(clk), .reset(reset), .load_i(shuffle_ok), .en_i(state_q == SHUFFLE),
    .seed_i(seed == 16'h0 ? DEFAULT_SEED : seed), .r_o(r)
  );
  // state and counter registers; everything is zeroed asynchronously
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= EMPTY;
      i_q <= '0;
      ptr_q <= '0;
      left_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      card_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      ptr_q <= ptr_d;
      left_q <= left_d;
      valid_q <= valid_d;
      err_q <= err_d;
      card_q <= card_d;
    end
  // deck array: identity fill in INIT, one indexed swap per accepted draw in SHUFFLE
  always_ff @(posedge clk)
    if (state_q == INIT) deck_q[i_q] <= i_q;
    else if (swap) begin
      deck_q[i_q] <= deck_q[r];
      deck_q[r] <= deck_q[i_q];
    end
  // next state, counters and the one-cycle deal/error pulses
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    ptr_d = ptr_q;
    left_d = left_q;
    valid_d = 1'b0;
    card_d = card_q;
    err_d = deal_req && (state_q != READY || left_q == 6'd0 || shuffle_ok);
    case (state_q)
      EMPTY, READY:
        if (shuffle_ok) begin
          state_d = INIT;
          i_d = '0;
          left_d = '0;
        end else if (state_q == READY && deal_req && left_q != 6'd0) begin
          valid_d = 1'b1;
          card_d = idx_to_card(deck_q[ptr_q]);
          ptr_d = ptr_q + 6'd1;
          left_d = left_q - 6'd1;
        end
      INIT:
        if (i_q == 6'(DECK_SIZE - 1)) begin
          state_d = SHUFFLE_EN ? SHUFFLE : READY;
          ptr_d = '0;
          left_d = SHUFFLE_EN ? 6'd0 : 6'(DECK_SIZE);
        end else i_d = i_q + 6'd1;
      SHUFFLE:
        if (swap) begin
          i_d = i_q - 6'd1;
          state_d = i_q == 6'd1 ? READY : SHUFFLE;
          left_d = i_q == 6'd1 ? 6'(DECK_SIZE) : 6'd0;
        end
      default: state_d = EMPTY;
    endcase
  end
  assign deal_valid = valid_q;
  assign deal_card = card_q;
  assign deal_err = err_q;
  assign deck_ready = state_q == READY;
  assign cards_left = left_q;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed checks of an in-order dealer and a shuffling dealer against a Fisher-Yates model
module tb_card_dealer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        sr [2];
  logic        dr [2];
  logic        dv [2];
  logic        de [2];
  logic        rdy [2];
  logic [5:0]  dc [2];
  logic [5:0]  cl [2];
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  mdeck [52];
  logic [5:0]  seqa [52];
  always #5 clk = ~clk;
  card_dealer #(.SHUFFLE_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .shuffle_req(sr[0]), .seed(seed), .deal_req(dr[0]),
    .deal_valid(dv[0]), .deal_card(dc[0]), .deal_err(de[0]), .deck_ready(rdy[0]), .cards_left(cl[0])
  );
  card_dealer #(.SHUFFLE_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .shuffle_req(sr[1]), .seed(seed), .deal_req(dr[1]),
    .deal_valid(dv[1]), .deal_card(dc[1]), .deal_err(de[1]), .deck_ready(rdy[1]), .cards_left(cl[1])
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] card_of(input int k);
    return 6'((k / 13) * 16 + k % 13 + 2);
  endfunction
  task automatic build_model(input logic [15:0] s);
    logic [15:0] l;
    logic [5:0]  t;
    int          i;
    bit          done;
    l = s == 16'h0 ? 16'hACE1 : s;
    for (int k = 0; k < 52; k++) mdeck[k] = 6'(k);
    i = 51;
    done = 1'b0;
    while (!done) begin
      if (int'(l[5:0]) <= i) begin
        t = mdeck[i];
        mdeck[i] = mdeck[l[5:0]];
        mdeck[l[5:0]] = t;
        if (i == 1) done = 1'b1;
        else i--;
      end
      l = l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
    end
  endtask
  task automatic shuffle(input int s, input logic [15:0] sd);
    @(negedge clk);
    sr[s] = 1'b1;
    seed = sd;
    @(negedge clk);
    sr[s] = 1'b0;
  endtask
  task automatic wait_ready(input int s);
    int n = 0;
    while (rdy[s] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 16'(rdy[s]), 16'h1);
  endtask
  task automatic deal(input int s);
    @(negedge clk);
    dr[s] = 1'b1;
    @(negedge clk);
    dr[s] = 1'b0;
  endtask
  task automatic deal_all(input logic [15:0] sd, input bit keep);
    bit seen [64];
    int uniq = 0;
    build_model(sd);
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++) begin
      deal(1);
      check("shuf_valid", 16'(dv[1]), 16'h1);
      check("shuf_card", 16'(dc[1]), 16'(card_of(int'(mdeck[k]))));
      check("shuf_left", 16'(cl[1]), 16'(51 - k));
      if (!seen[dc[1]]) uniq++;
      seen[dc[1]] = 1'b1;
      if (keep) seqa[k] = dc[1];
      else check("repeat_seq", 16'(dc[1]), 16'(seqa[k]));
    end
    check("distinct", 16'(uniq), 16'd52);
  endtask
  initial begin
    sr[0] = 1'b0; sr[1] = 1'b0; dr[0] = 1'b0; dr[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 16'(rdy[1]), 16'h0);
    check("rst_left", 16'(cl[1]), 16'h0);
    check("rst_card", 16'(dc[1]), 16'h0);
    check("rst_valid", 16'(dv[1]), 16'h0);
    reset = 1'b1;
    deal(0);
    check("empty_err", 16'(de[0]), 16'h1);
    check("empty_valid", 16'(dv[0]), 16'h0);
    shuffle(0, 16'h0);
    wait_ready(0);
    check("inorder_left52", 16'(cl[0]), 16'd52);
    dr[0] = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      check("inorder_valid", 16'(dv[0]), 16'h1);
      check("inorder_card", 16'(dc[0]), 16'(card_of(k)));
      check("inorder_left", 16'(cl[0]), 16'(51 - k));
    end
    @(negedge clk);
    dr[0] = 1'b0;
    check("deal53_err", 16'(de[0]), 16'h1);
    check("deal53_valid", 16'(dv[0]), 16'h0);
    check("deal53_left", 16'(cl[0]), 16'h0);
    check("deal53_hold", 16'(dc[0]), 16'h3E);
    check("deal53_ready", 16'(rdy[0]), 16'h1);
    shuffle(1, 16'h1234);
    wait_ready(1);
    check("shuf_left52", 16'(cl[1]), 16'd52);
    deal_all(16'h1234, 1'b1);
    shuffle(1, 16'h1234);
    wait_ready(1);
    deal_all(16'h1234, 1'b0);
    shuffle(1, 16'h0);
    repeat (60) @(negedge clk);
    shuffle(1, 16'h5555);
    wait_ready(1);
    deal_all(16'h0, 1'b1);
    shuffle(1, 16'hACE1);
    wait_ready(1);
    deal_all(16'hACE1, 1'b0);
    @(negedge clk);
    sr[1] = 1'b1;
    dr[1] = 1'b1;
    seed = 16'h1234;
    @(negedge clk);
    sr[1] = 1'b0;
    dr[1] = 1'b0;
    check("both_err", 16'(de[1]), 16'h1);
    check("both_valid", 16'(dv[1]), 16'h0);
    check("both_notready", 16'(rdy[1]), 16'h0);
    wait_ready(1);
    check("both_left52", 16'(cl[1]), 16'd52);
    build_model(16'h1234);
    deal(1);
    check("both_first", 16'(dc[1]), 16'(card_of(int'(mdeck[0]))));
    shuffle(1, 16'h1234);
    repeat (60) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", 16'(rdy[1]), 16'h0);
    check("midrst_left", 16'(cl[1]), 16'h0);
    check("midrst_card", 16'(dc[1]), 16'h0);
    check("midrst_valid", 16'(dv[1]), 16'h0);
    check("midrst_err", 16'(de[1]), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    deal(1);
    check("midrst_deal_err", 16'(de[1]), 16'h1);
    check("midrst_deal_valid", 16'(dv[1]), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
